// File: rtl/output_scan_controller.sv
// Output buffer sequencer: CPU stores always win the buffer port; a scanner walks the
// slots round-robin and presents each word to a display sink. Optional: OUTPUT_SCAN_DIRTY_EN.
module output_scan_controller #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned SLOTS      = 8,
  parameter int unsigned BASE_ADDR  = 0,
  parameter int unsigned DWELL      = 1000
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     enable,
  input  logic                     cpu_mem_write,
  input  logic [DATA_WIDTH-1:0]    cpu_addr,
  input  logic [DATA_WIDTH-1:0]    cpu_wdata,
  output logic                     mem_we,
  output logic [$clog2(SLOTS)-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]    mem_wdata,
  input  logic [DATA_WIDTH-1:0]    mem_rdata,
  output logic                     disp_valid,
  input  logic                     disp_ready,
  output logic [$clog2(SLOTS)-1:0] disp_index,
  output logic [DATA_WIDTH-1:0]    disp_data
);

  localparam int unsigned IDX_W = $clog2(SLOTS);
  localparam int unsigned CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [DATA_WIDTH-1:0] BASE_W  = DATA_WIDTH'(BASE_ADDR);
  localparam logic [DATA_WIDTH-1:0] SLOTS_W = DATA_WIDTH'(SLOTS);

  typedef enum logic [2:0] {IDLE, READ, WAIT, PRESENT, HOLD} state_e;

  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        ptr_q, ptr_d;
  logic                    valid_q, valid_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;

  logic [DATA_WIDTH-1:0]   cpu_off;
  logic                    cpu_hit;
  logic [IDX_W-1:0]        cpu_slot;
  logic                    rd_ok;
  logic [IDX_W-1:0]        rd_slot;
  logic                    rd_addr_en;

  // Offset compare avoids overflow of BASE_ADDR+SLOTS; gating by reset_n blocks writes in reset.
  assign cpu_off  = cpu_addr - BASE_W;
  assign cpu_hit  = reset_n && cpu_mem_write && (cpu_addr >= BASE_W) && (cpu_off < SLOTS_W);
  assign cpu_slot = cpu_off[IDX_W-1:0];

`ifdef OUTPUT_SCAN_DIRTY_EN
  logic [SLOTS-1:0] dirty_q, dirty_d;
  logic [IDX_W-1:0] cand;

  // Descending walk so the nearest set slot at or after the pointer is the last assignment.
  always_comb begin
    rd_ok   = 1'b0;
    rd_slot = ptr_q;
    cand    = '0;
    for (int i = SLOTS - 1; i >= 0; i--) begin
      cand = ptr_q + IDX_W'(i);
      if (dirty_q[cand]) begin
        rd_ok   = 1'b1;
        rd_slot = cand;
      end
    end
  end

  always_comb begin
    dirty_d = dirty_q;
    if (state_q == WAIT && !(cpu_hit && cpu_slot == ptr_q)) dirty_d[ptr_q] = 1'b0;
    if (cpu_hit) dirty_d[cpu_slot] = 1'b1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) dirty_q <= '0;
    else          dirty_q <= dirty_d;
  end
`else
  assign rd_ok   = 1'b1;
  assign rd_slot = ptr_q;
`endif

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    valid_d    = valid_q;
    idx_d      = idx_q;
    data_d     = data_q;
    cnt_d      = cnt_q;
    rd_addr_en = 1'b0;
    case (state_q)
      IDLE: if (enable) state_d = READ;
      // A read is only issued on a hit-free cycle, so staleness can only arise in WAIT.
      READ: if (!cpu_hit && rd_ok) begin
        rd_addr_en = 1'b1;
        ptr_d      = rd_slot;
        state_d    = WAIT;
      end
      WAIT: if (cpu_hit && cpu_slot == ptr_q) begin
        state_d = READ;
      end else begin
        data_d  = mem_rdata;
        idx_d   = ptr_q;
        valid_d = 1'b1;
        state_d = PRESENT;
      end
      PRESENT: if (disp_ready) begin
        valid_d = 1'b0;
        cnt_d   = CNT_W'(DWELL - 1);
        state_d = HOLD;
      end
      HOLD: if (cnt_q > CNT_W'(1)) begin
        cnt_d = cnt_q - 1'b1;
      end else begin
        cnt_d   = '0;
        ptr_d   = ptr_q + 1'b1;
        state_d = enable ? READ : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_we    = cpu_hit;
    mem_addr  = '0;
    mem_wdata = '0;
    if (cpu_hit) begin
      mem_addr  = cpu_slot;
      mem_wdata = cpu_wdata;
    end else if (rd_addr_en) begin
      mem_addr = rd_slot;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      valid_q <= 1'b0;
      idx_q   <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      valid_q <= valid_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

  assign disp_valid = valid_q;
  assign disp_index = idx_q;
  assign disp_data  = data_q;

endmodule

// File: doc/output_scan_controller.md
Name: output_scan_controller

Overview:
- Sequences the memory-mapped output buffer between two requesters: CPU store traffic (write port) and a display scanner (read port).
- The scanner walks SLOTS output words round-robin and presents each one to a display sink over a valid/ready handshake.
- Each presented word is held for at least DWELL cycles.
- Sits between the CPU data-memory store path and the output buffer RAM, replacing direct CPU drive of the buffer's write and strobe inputs.

Parameters:
DATA_WIDTH, 32, width of address and data words
SLOTS, 8, number of output words scanned; power of two, 2..256
BASE_ADDR, 0, CPU word address of slot 0
DWELL, 1000, minimum cycles each word stays on disp_data after acceptance; >=1

Ports:
clock  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
enable  in  1  scanner run; 0 finishes the current handshake, then parks in IDLE
cpu_mem_write  in  1  CPU store strobe
cpu_addr  in  DATA_WIDTH  CPU store word address
cpu_wdata  in  DATA_WIDTH  CPU store data
mem_we  out  1  buffer write enable
mem_addr  out  $clog2(SLOTS)  buffer address (write or read)
mem_wdata  out  DATA_WIDTH  buffer write data
mem_rdata  in  DATA_WIDTH  buffer read data, valid 1 cycle after address (registered read)
disp_valid  out  1  disp_index/disp_data valid
disp_ready  in  1  sink accepts when valid&ready
disp_index  out  $clog2(SLOTS)  slot being presented
disp_data  out  DATA_WIDTH  word being presented

Behaviour:
- Reset (async assert, sync release): state IDLE, scan pointer 0, mem_we 0, mem_addr 0, mem_wdata 0, disp_valid 0, disp_index 0, disp_data 0, dwell counter 0.
- CPU hit: cpu_mem_write=1 and BASE_ADDR <= cpu_addr < BASE_ADDR+SLOTS, compared unsigned at full DATA_WIDTH.
- A hit drives mem_we=1, mem_addr=cpu_addr-BASE_ADDR and mem_wdata=cpu_wdata combinationally in the same cycle.
- Misses are ignored: mem_we=0, no buffer change.
- The CPU always wins the port; the CPU is never stalled.
- FSM states: IDLE, READ, WAIT, PRESENT, HOLD.
  - IDLE: enable=1 -> READ.
  - READ: if no CPU hit this cycle, drive mem_addr=pointer, go to WAIT. Otherwise stay in READ (retry next cycle).
  - WAIT: capture mem_rdata into disp_data, disp_index=pointer, set disp_valid=1, go to PRESENT.
    - Exception: a CPU hit to the same slot in the previous READ cycle or in this cycle makes the read stale; go back to READ, disp_valid stays 0.
  - PRESENT: hold disp_valid=1 until disp_ready=1.
    - On acceptance: disp_valid=0, load dwell counter with DWELL-1, go to HOLD.
    - disp_data/disp_index must not change while disp_valid=1, even if the CPU writes that slot. The new value appears on the next pass.
  - HOLD: decrement the counter each cycle. At 0, pointer advances (wraps SLOTS-1 -> 0); next state is READ if enable=1, else IDLE.
    - disp_data keeps its last value in HOLD and IDLE.
- Read latency: READ to disp_valid is exactly 2 cycles when uncontended.
- Uncontended throughput: one slot per DWELL+2 cycles plus sink wait.
- enable deassert takes effect only at the HOLD exit or in IDLE. READ, WAIT and PRESENT always complete.
- Mid-operation reset: all state returns to reset values immediately. No partial buffer write may be issued after reset asserts (mem_we is gated by reset_n).

Optional Feature:
- Macro: OUTPUT_SCAN_DIRTY_EN.
- Defined:
  - Adds a SLOTS-bit dirty vector, cleared at reset. A CPU hit sets the bit for its slot.
  - READ skips slots whose bit is clear, searching from the pointer, lowest index after the pointer first, wrapping.
  - If no bits are set, the FSM stays in READ and issues no buffer read.
  - A slot's bit clears in WAIT on a non-stale capture. A CPU hit in that same cycle re-sets it (set wins).
- Undefined: every slot is scanned unconditionally as above.

Test Plan:
- Reset, enable=1, buffer preloaded slot k = 0x100+k, DWELL=4, disp_ready=1 -> disp_index sequence 0,1,...,7,0 with disp_data 0x100..0x107, a new valid every 6 cycles.
- CPU store addr BASE_ADDR+3, data 0xDEADBEEF, while the scanner is in READ for slot 3 -> mem_we=1 with mem_addr=3 that cycle, scanner retries, presents 0xDEADBEEF.
- CPU store to addr BASE_ADDR+SLOTS (8) and addr BASE_ADDR-1 -> mem_we stays 0, buffer unchanged.
- disp_ready held 0 for 20 cycles while the CPU rewrites the presented slot with 0x55 -> disp_valid stays 1, disp_data unchanged; 0x55 shown on the next pass.
- reset_n pulsed low mid-HOLD and mid-CPU-write -> all outputs 0 asynchronously; after release, scan restarts at slot 0.
- With OUTPUT_SCAN_DIRTY_EN: after reset, write only slots 2 and 6 -> presented indices 2,6, then no disp_valid until the next write.
